// File: rtl/pipeline_perf_monitor_if.sv
// Observer-side bundle for pipeline_perf_monitor.
// The processor/bench drives the master side; the monitor takes the slave side.
interface pipeline_perf_monitor_if #(
  parameter int CNT_W = 32
);
  logic             forwarding_EN;
  logic             wb_valid;
  logic             stall;
  logic             flush;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             halt;
  logic             rd_req;
  logic [2:0]       rd_addr;
  logic             rd_ack;
  logic [CNT_W-1:0] rd_data;
  logic             running;
  logic             done;

  modport master (
    output forwarding_EN, wb_valid, stall, flush,
    output fwd_a_sel, fwd_b_sel, halt,
    output rd_req, rd_addr,
    input  rd_ack, rd_data, running, done
  );

  modport slave (
    input  forwarding_EN, wb_valid, stall, flush,
    input  fwd_a_sel, fwd_b_sel, halt,
    input  rd_req, rd_addr,
    output rd_ack, rd_data, running, done
  );
endinterface

// File: rtl/pipeline_perf_monitor.sv
// Write-back performance observer: saturating run statistics,
// halt-driven freeze after the pipeline drains, registered read port.
module pipeline_perf_monitor #(
  parameter int CNT_W     = 32,
  parameter int DRAIN_CYC = 4
) (
  input logic clk,
  input logic rst,
  pipeline_perf_monitor_if.slave bus
);
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic             r_running;
  logic             r_done;
  logic             r_fen;
  logic [DW-1:0]    r_drain;
  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_ret;
  logic [CNT_W-1:0] r_stl;
  logic [CNT_W-1:0] r_fls;
  logic [CNT_W-1:0] r_fwd;
  logic             r_rd_ack;
  logic [CNT_W-1:0] r_rd_data;

  logic             w_cnt_en;
  logic             w_fwd_ev;
  logic [CNT_W-1:0] w_rd_val;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    if (en && (v != {CNT_W{1'b1}}))
      return v + CNT_W'(1);
    return v;
  endfunction

  assign w_cnt_en = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_fwd_ev = r_fen &&
    ((bus.fwd_a_sel != 2'd0) || (bus.fwd_b_sel != 2'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_fen     <= 1'b0;
      r_drain   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_state   <= S_RUN;
          r_running <= 1'b1;
          r_fen     <= bus.forwarding_EN;
        end
        S_RUN: begin
          if (bus.halt) begin
            r_state <= S_DRAIN;
            r_drain <= DW'(DRAIN_CYC - 1);
          end
        end
        S_DRAIN: begin
          if (r_drain == '0) begin
            r_state   <= S_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_drain <= r_drain - DW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc <= '0;
      r_ret <= '0;
      r_stl <= '0;
      r_fls <= '0;
      r_fwd <= '0;
    end else if (w_cnt_en) begin
      r_cyc <= sat_inc(r_cyc, 1'b1);
      r_ret <= sat_inc(r_ret, bus.wb_valid);
      r_stl <= sat_inc(r_stl, bus.stall);
      r_fls <= sat_inc(r_fls, bus.flush);
      r_fwd <= sat_inc(r_fwd, w_fwd_ev);
    end
  end

  always_comb begin
    w_rd_val = '0;
    case (bus.rd_addr)
      3'd0: w_rd_val = r_cyc;
      3'd1: w_rd_val = r_ret;
      3'd2: w_rd_val = r_stl;
      3'd3: w_rd_val = r_fls;
      3'd4: w_rd_val = r_fwd;
      3'd5: w_rd_val[2:0] = {r_done, r_running, r_fen};
      default: w_rd_val = '0;
    endcase
  end

  // Sampled before this edge's counter update, so reads see pre-increment values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_ack <= bus.rd_req;
      if (bus.rd_req)
        r_rd_data <= w_rd_val;
    end
  end

  assign bus.rd_ack  = r_rd_ack;
  assign bus.rd_data = r_rd_data;
  assign bus.running = r_running;
  assign bus.done    = r_done;
endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Directed bench for pipeline_perf_monitor: vector table
// for the frozen read map plus hand sequences for timing cases.
module tb_pipeline_perf_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst4 = 1'b1;

  int n_chk = 0;
  int n_fail = 0;

  pipeline_perf_monitor_if #(.CNT_W(32)) bus();
  pipeline_perf_monitor_if #(.CNT_W(4))  bus4();

  pipeline_perf_monitor #(.CNT_W(32), .DRAIN_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipeline_perf_monitor #(.CNT_W(4), .DRAIN_CYC(4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [2:0]  addr;
    logic [31:0] exp;
  } vec_t;

  vec_t tv[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.rd_req  = 1'b1;
    bus.rd_addr = a;
    tick();
    bus.rd_req = 1'b0;
    chk("rd_ack", {31'd0, bus.rd_ack}, 32'd1);
    d = bus.rd_data;
  endtask

  task automatic rd4(input logic [2:0] a, output logic [31:0] d);
    bus4.rd_req  = 1'b1;
    bus4.rd_addr = a;
    tick();
    bus4.rd_req = 1'b0;
    chk("rd4_ack", {31'd0, bus4.rd_ack}, 32'd1);
    d = {28'd0, bus4.rd_data};
  endtask

  task automatic clr_in();
    bus.wb_valid  = 1'b0;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.fwd_a_sel = 2'd0;
    bus.fwd_b_sel = 2'd0;
    bus.halt      = 1'b0;
    bus.rd_req    = 1'b0;
    bus.rd_addr   = 3'd0;
  endtask

  task automatic fwd_pattern();
    bus.fwd_a_sel = 2'd1;
    bus.fwd_b_sel = 2'd2;
    repeat (3) tick();
    bus.fwd_a_sel = 2'd0;
    repeat (2) tick();
    bus.fwd_b_sel = 2'd0;
  endtask

  initial begin
    logic [31:0] d;
    int k;

    tv[0] = '{"frz_cyc", 3'd0, 32'd15};
    tv[1] = '{"frz_ret", 3'd1, 32'd15};
    tv[2] = '{"frz_stl", 3'd2, 32'd0};
    tv[3] = '{"frz_fls", 3'd3, 32'd0};
    tv[4] = '{"frz_fwd", 3'd4, 32'd0};
    tv[5] = '{"frz_status", 3'd5, 32'd5};
    tv[6] = '{"frz_addr6", 3'd6, 32'd0};
    tv[7] = '{"frz_addr7", 3'd7, 32'd0};

    clr_in();
    bus.forwarding_EN = 1'b1;
    bus4.forwarding_EN = 1'b0;
    bus4.wb_valid  = 1'b1;
    bus4.stall     = 1'b0;
    bus4.flush     = 1'b0;
    bus4.fwd_a_sel = 2'd0;
    bus4.fwd_b_sel = 2'd0;
    bus4.halt      = 1'b0;
    bus4.rd_req    = 1'b0;
    bus4.rd_addr   = 3'd0;

    // Reset, retire, halt (halt also held during the IDLE edge)
    repeat (2) tick();
    chk("rst_running", {31'd0, bus.running}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_ack", {31'd0, bus.rd_ack}, 32'd0);
    chk("rst_data", bus.rd_data, 32'd0);
    rst = 1'b0;
    bus.wb_valid = 1'b1;
    bus.halt = 1'b1;
    tick();
    chk("run_rise", {31'd0, bus.running}, 32'd1);
    bus.halt = 1'b0;
    repeat (10) tick();
    chk("idle_halt_ignored", {31'd0, bus.running}, 32'd1);
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    chk("drain_running", {31'd0, bus.running}, 32'd1);
    k = 1;
    while (!bus.done && k < 20) begin
      tick();
      k++;
    end
    chk("done_latency", k, 32'd5);
    chk("done_running", {31'd0, bus.running}, 32'd0);
    bus.wb_valid = 1'b0;

    foreach (tv[i]) begin
      rd(tv[i].addr, d);
      chk(tv[i].nm, d, tv[i].exp);
    end

    bus.wb_valid  = 1'b1;
    bus.stall     = 1'b1;
    bus.flush     = 1'b1;
    bus.fwd_a_sel = 2'd3;
    bus.halt      = 1'b1;
    repeat (20) tick();
    for (int a = 0; a < 5; a++) begin
      rd(3'(a), d);
      chk("frozen_later", d, tv[a].exp);
    end
    chk("done_held", {31'd0, bus.done}, 32'd1);
    clr_in();

    // Forwarding enabled
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.forwarding_EN = 1'b1;
    tick();
    fwd_pattern();
    rd(3'd4, d);
    chk("fwd_en_cnt", d, 32'd5);
    rd(3'd5, d);
    chk("fwd_en_status", d, 32'd3);

    // Forwarding disabled at start; later enable must not matter
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.forwarding_EN = 1'b0;
    tick();
    bus.forwarding_EN = 1'b1;
    fwd_pattern();
    rd(3'd4, d);
    chk("fwd_dis_cnt", d, 32'd0);
    rd(3'd5, d);
    chk("fwd_dis_status", d, 32'd2);

    // Simultaneous events
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    bus.wb_valid = 1'b1;
    repeat (4) tick();
    clr_in();
    rd(3'd0, d);
    chk("sim_cyc", d, 32'd4);
    rd(3'd1, d);
    chk("sim_ret", d, 32'd4);
    rd(3'd2, d);
    chk("sim_stl", d, 32'd4);
    rd(3'd3, d);
    chk("sim_fls", d, 32'd4);

    // Read timing: held rd_req, back-to-back, pre-increment data
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.forwarding_EN = 1'b1;
    tick();
    repeat (3) tick();
    chk("rt_idle_ack", {31'd0, bus.rd_ack}, 32'd0);
    bus.rd_req = 1'b1;
    bus.rd_addr = 3'd0;
    tick();
    chk("rt_ack0", {31'd0, bus.rd_ack}, 32'd1);
    chk("rt_cyc_pre", bus.rd_data, 32'd3);
    bus.rd_addr = 3'd6;
    tick();
    chk("rt_ack1", {31'd0, bus.rd_ack}, 32'd1);
    chk("rt_addr6", bus.rd_data, 32'd0);
    bus.rd_addr = 3'd1;
    tick();
    chk("rt_ack2", {31'd0, bus.rd_ack}, 32'd1);
    chk("rt_ret", bus.rd_data, 32'd0);
    bus.rd_addr = 3'd5;
    tick();
    chk("rt_ack3", {31'd0, bus.rd_ack}, 32'd1);
    chk("rt_status", bus.rd_data, 32'd3);
    bus.rd_req = 1'b0;
    tick();
    chk("rt_ack_drop", {31'd0, bus.rd_ack}, 32'd0);
    chk("rt_data_hold", bus.rd_data, 32'd3);
    rd(3'd0, d);
    chk("rt_cyc_later", d, 32'd8);

    // Reset during DRAIN with a pending read
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.wb_valid = 1'b1;
    tick();
    repeat (3) tick();
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    tick();
    chk("dr_running", {31'd0, bus.running}, 32'd1);
    chk("dr_done", {31'd0, bus.done}, 32'd0);
    bus.rd_req = 1'b1;
    bus.rd_addr = 3'd1;
    tick();
    chk("dr_ack", {31'd0, bus.rd_ack}, 32'd1);
    rst = 1'b1;
    tick();
    chk("dr_rst_ack", {31'd0, bus.rd_ack}, 32'd0);
    chk("dr_rst_data", bus.rd_data, 32'd0);
    chk("dr_rst_running", {31'd0, bus.running}, 32'd0);
    chk("dr_rst_done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0;
    clr_in();
    tick();
    for (int a = 0; a < 5; a++) begin
      rd(3'(a), d);
      chk("dr_cnt_zero", d, 32'd0);
    end
    repeat (8) tick();
    chk("dr_no_stale_done", {31'd0, bus.done}, 32'd0);
    chk("dr_still_run", {31'd0, bus.running}, 32'd1);

    // Saturation on the 4-bit instance
    rst4 = 1'b0;
    tick();
    repeat (20) tick();
    rd4(3'd0, d);
    chk("sat_cyc", d, 32'd15);
    rd4(3'd1, d);
    chk("sat_ret", d, 32'd15);
    rd4(3'd2, d);
    chk("sat_stl", d, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
